// File: rtl/schmidl_cox_pkg.sv
// Shared types and default sizing for the Schmidl-Cox frame gate.
//   gate_state_t     : controller states (SEARCH, PEAK, WAIT, FRAME)
//   DEF_*            : default widths and lengths for the frame gate
//   SAMPLE_W         : width of a packed complex sample (16-bit I + 16-bit Q)
package schmidl_cox_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    PEAK   = 2'd1,
    WAIT   = 2'd2,
    FRAME  = 2'd3
  } gate_state_t;

  // 32-bit power terms summed over CP_SIZE = 128 samples.
  localparam int DEF_METRIC_WIDTH = 40;
  localparam int DEF_PEAK_WIN     = 128;
  localparam int DEF_START_OFFSET = 256;
  localparam int DEF_FRAME_LEN    = 1152;
  localparam int SAMPLE_W         = 32;

endpackage

// File: rtl/peak_tracker.sv
// Running max/argmax over the peak search window.
//   init       : trigger sample accepted; max = metric, argmax = 0, index = 1
//   step       : one window sample accepted; strict-greater update, index++
//   clear      : synchronous return of the index counters to zero
//   metric     : current metric sample
//   best_value : window maximum including the sample being stepped this cycle
//   best_idx   : window argmax including the sample being stepped this cycle
//   done       : the step in progress is the last sample of the window
module peak_tracker
  import schmidl_cox_pkg::*;
#(
  parameter  int METRIC_WIDTH = DEF_METRIC_WIDTH,
  parameter  int PEAK_WIN     = DEF_PEAK_WIN,
  localparam int IDX_W        = $clog2(PEAK_WIN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    init,
  input  logic                    step,
  input  logic [METRIC_WIDTH-1:0] metric,
  output logic [METRIC_WIDTH-1:0] best_value,
  output logic [IDX_W-1:0]        best_idx,
  output logic                    done
);

  logic [METRIC_WIDTH-1:0] max_q;
  logic [IDX_W-1:0]        p_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    new_max;

  // Strict compare: an equal later value never moves the argmax.
  assign new_max    = metric > max_q;
  // Look-through values so the closing sample can still win the window.
  assign best_value = (step && new_max) ? metric : max_q;
  assign best_idx   = (step && new_max) ? idx_q  : p_q;
  assign done       = step && (idx_q == IDX_W'(PEAK_WIN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      p_q   <= '0;
    end else if (clear) begin
      idx_q <= '0;
      p_q   <= '0;
    end else if (init) begin
      idx_q <= IDX_W'(1);
      p_q   <= '0;
    end else if (step) begin
      idx_q <= idx_q + 1'b1;
      if (new_max) p_q <= idx_q;
    end
  end

  // Max value is always loaded by init before it is read.
  always_ff @(posedge clk) begin
    if (init) max_q <= metric;
    else if (step && new_max) max_q <= metric;
  end

endmodule

// File: rtl/schmidl_cox_frame_gate.sv
// Frame gate behind the Schmidl-Cox metric calculator.
// Joins the metric and delayed-sample streams, triggers on metric >= threshold,
// finds the first maximum over a PEAK_WIN window, skips to START_OFFSET past the
// peak and forwards FRAME_LEN samples with tlast.
//   clk, reset          : clock, asynchronous active-high reset
//   clear               : synchronous return to SEARCH (detect_count kept)
//   threshold           : unsigned trigger level, used in SEARCH
//   m_t*                : metric stream (tlast ignored)
//   s_t*                : index-aligned sample stream (tlast ignored)
//   o_t*                : gated frame output, zero-latency pass-through of s_*
//   detect_pulse        : one-cycle strobe after the window closes
//   peak_value          : window maximum of the last detection
//   detect_count        : wrapping count of detections since reset
module schmidl_cox_frame_gate
  import schmidl_cox_pkg::*;
#(
  parameter int METRIC_WIDTH = DEF_METRIC_WIDTH,
  parameter int PEAK_WIN     = DEF_PEAK_WIN,
  parameter int START_OFFSET = DEF_START_OFFSET,
  parameter int FRAME_LEN    = DEF_FRAME_LEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [METRIC_WIDTH-1:0] threshold,
  input  logic [METRIC_WIDTH-1:0] m_tdata,
  input  logic                    m_tlast,
  input  logic                    m_tvalid,
  output logic                    m_tready,
  input  logic [SAMPLE_W-1:0]     s_tdata,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [SAMPLE_W-1:0]     o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    detect_pulse,
  output logic [METRIC_WIDTH-1:0] peak_value,
  output logic [15:0]             detect_count
);

  localparam int IDX_W  = $clog2(PEAK_WIN);
  localparam int WAIT_W = $clog2(START_OFFSET);
  localparam int FRM_W  = $clog2(FRAME_LEN);

  gate_state_t             state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    in_frame;
  logic                    fire;
  logic                    trig;
  logic                    win_step;
  logic                    win_done;
  logic [METRIC_WIDTH-1:0] best_value;
  logic [IDX_W-1:0]        best_idx;
  logic [WAIT_W-1:0]       wait_init;
  logic                    unused_tlast;

  // Samples to drop after the window so the frame opens START_OFFSET past the peak.
  function automatic logic [WAIT_W-1:0] wait_load(input logic [IDX_W-1:0] p);
    return WAIT_W'(int'(p) + START_OFFSET - PEAK_WIN);
  endfunction

  assign unused_tlast = m_tlast ^ s_tlast;

  // Outside FRAME the streams are drained freely; in FRAME the sink paces both.
  assign in_frame = (state == FRAME);
  assign fire     = m_tvalid && s_tvalid && (!in_frame || o_tready);
  assign m_tready = fire;
  assign s_tready = fire;

  // o_tvalid depends only on state and the input valids, never on o_tready.
  assign o_tvalid = in_frame && m_tvalid && s_tvalid;
  assign o_tdata  = in_frame ? s_tdata : '0;
  assign o_tlast  = o_tvalid && (frame_cnt == FRM_W'(FRAME_LEN - 1));

  assign trig      = fire && !clear && (state == SEARCH) && (m_tdata >= threshold);
  assign win_step  = fire && !clear && (state == PEAK);
  assign wait_init = wait_load(best_idx);

  peak_tracker #(
    .METRIC_WIDTH (METRIC_WIDTH),
    .PEAK_WIN     (PEAK_WIN)
  ) u_peak (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .init       (trig),
    .step       (win_step),
    .metric     (m_tdata),
    .best_value (best_value),
    .best_idx   (best_idx),
    .done       (win_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      wait_cnt     <= '0;
      frame_cnt    <= '0;
      detect_pulse <= 1'b0;
      peak_value   <= '0;
      detect_count <= '0;
    end else begin
      detect_pulse <= 1'b0;
      if (clear) begin
        // Truncates any open frame; the sample in this cycle is simply dropped.
        state     <= SEARCH;
        wait_cnt  <= '0;
        frame_cnt <= '0;
      end else if (fire) begin
        unique case (state)
          SEARCH: if (trig) state <= PEAK;
          PEAK: begin
            if (win_done) begin
              detect_pulse <= 1'b1;
              peak_value   <= best_value;
              detect_count <= detect_count + 16'd1;
              wait_cnt     <= wait_init;
              state        <= (wait_init == '0) ? FRAME : WAIT;
            end
          end
          WAIT: begin
            wait_cnt <= wait_cnt - 1'b1;
            if (wait_cnt == WAIT_W'(1)) state <= FRAME;
          end
          FRAME: begin
            if (frame_cnt == FRM_W'(FRAME_LEN - 1)) begin
              frame_cnt <= '0;
              state     <= SEARCH;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_schmidl_cox_frame_gate.sv
// Self-checking bench for schmidl_cox_frame_gate. Two instances share the
// stimulus: dut_a uses the default offset, dut_b the minimum offset (= PEAK_WIN).
// The driver follows the handshake of whichever instance is selected. Expected
// frames and detections come from a window/argmax scan over the stimulus arrays.
module tb_schmidl_cox_frame_gate;

  localparam int MW   = 40;
  localparam int PW   = 128;
  localparam int SO   = 256;
  localparam int SO_B = 128;
  localparam int FL   = 1152;
  localparam int NMAX = 4000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [MW-1:0] threshold;
  logic [MW-1:0] m_tdata;
  logic          m_tlast, mv, sv, s_tlast, otr;
  logic [31:0]   s_tdata;

  logic          a_mtr, a_str, a_otl, a_otv, a_dp;
  logic [31:0]   a_otd;
  logic [MW-1:0] a_pval;
  logic [15:0]   a_dcnt;
  logic          b_mtr, b_str, b_otl, b_otv, b_dp;
  logic [31:0]   b_otd;
  logic [MW-1:0] b_pval;
  logic [15:0]   b_dcnt;

  bit            sel;
  logic          v_mtr, v_str, v_otl, v_otv, v_dp;
  logic [31:0]   v_otd;
  logic [MW-1:0] v_pval;
  logic [15:0]   v_dcnt;

  assign v_mtr  = sel ? b_mtr  : a_mtr;
  assign v_str  = sel ? b_str  : a_str;
  assign v_otl  = sel ? b_otl  : a_otl;
  assign v_otv  = sel ? b_otv  : a_otv;
  assign v_dp   = sel ? b_dp   : a_dp;
  assign v_otd  = sel ? b_otd  : a_otd;
  assign v_pval = sel ? b_pval : a_pval;
  assign v_dcnt = sel ? b_dcnt : a_dcnt;

  always #5 clk = ~clk;

  schmidl_cox_frame_gate #(.METRIC_WIDTH(MW), .PEAK_WIN(PW), .START_OFFSET(SO), .FRAME_LEN(FL)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(mv), .m_tready(a_mtr),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(sv), .s_tready(a_str),
    .o_tdata(a_otd), .o_tlast(a_otl), .o_tvalid(a_otv), .o_tready(otr),
    .detect_pulse(a_dp), .peak_value(a_pval), .detect_count(a_dcnt));

  schmidl_cox_frame_gate #(.METRIC_WIDTH(MW), .PEAK_WIN(PW), .START_OFFSET(SO_B), .FRAME_LEN(FL)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(mv), .m_tready(b_mtr),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(sv), .s_tready(b_str),
    .o_tdata(b_otd), .o_tlast(b_otl), .o_tvalid(b_otv), .o_tready(otr),
    .detect_pulse(b_dp), .peak_value(b_pval), .detect_count(b_dcnt));

  logic [MW-1:0] met [NMAX];
  logic [31:0]   smp [NMAX];
  bit            inframe [NMAX];

  int            exp_idx[$];
  bit            exp_last[$];
  int            exp_det_at[$];
  logic [MW-1:0] exp_det_val[$];
  int            n_before;
  logic [32:0]   got_q[$];
  int            got_det_at[$];
  logic [MW-1:0] got_det_val[$];
  int            viol;
  int            checks = 0;
  int            failures = 0;
  int            c_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: scan [lo,hi) for a crossing, take the first maximum of
  // the next PW samples, then emit FL samples starting at trigger+argmax+so.
  // Anything that would reach hi is cut there (clear/reset boundary or stream end).
  function automatic void scan(input int lo, input int hi, input int so);
    int i, t, p, fs;
    logic [MW-1:0] best;
    i = lo;
    while (i < hi) begin
      t = -1;
      for (int j = i; j < hi; j++) begin
        if (met[j] >= threshold) begin
          t = j;
          break;
        end
      end
      if (t < 0 || t + PW - 1 >= hi) return;
      best = met[t];
      p = 0;
      for (int k = 1; k < PW; k++) begin
        if (met[t+k] > best) begin
          best = met[t+k];
          p = k;
        end
      end
      exp_det_at.push_back(t + PW - 1);
      exp_det_val.push_back(best);
      fs = t + p + so;
      for (int k = 0; k < FL && fs + k < hi; k++) begin
        exp_idx.push_back(fs + k);
        exp_last.push_back(k == FL - 1);
      end
      i = fs + FL;
    end
  endfunction

  function automatic void build_model(input int n, input int so, input int brk);
    exp_idx.delete(); exp_last.delete(); exp_det_at.delete(); exp_det_val.delete();
    if (brk < 0) begin
      scan(0, n, so);
      n_before = 0;
    end else begin
      scan(0, brk, so);
      n_before = exp_det_at.size();
      scan(brk, n, so);
    end
    for (int i = 0; i < NMAX; i++) inframe[i] = 1'b0;
    foreach (exp_idx[i]) inframe[exp_idx[i]] = 1'b1;
  endfunction

  function automatic void setup_base();
    for (int i = 0; i < NMAX; i++) begin
      met[i] = '0;
      smp[i] = $urandom;
    end
  endfunction

  function automatic void setup_single(input bit tie);
    setup_base();
    met[100] = MW'(2000);
    met[101] = MW'(3000);
    for (int i = 102; i <= 151; i++) met[i] = MW'(1500);
    if (tie) met[105] = MW'(3000);
  endfunction

  function automatic void setup_random();
    int b1, b2;
    setup_base();
    for (int i = 0; i < NMAX; i++) met[i] = MW'($urandom_range(0, 900));
    b1 = $urandom_range(20, 200);
    b2 = b1 + 1700;
    for (int i = 0; i < 40; i++) begin
      met[b1+i]     = MW'($urandom_range(1000, 1100));
      met[b1+600+i] = MW'($urandom_range(1000, 5000));
      met[b2+i]     = MW'($urandom_range(1000, 1100));
    end
    met[b2]    = MW'(1000);
    met[b2+17] = {8'h01, 32'($urandom)};
  endfunction

  task automatic start_phase(input string ph, input bit s);
    sel = s;
    mv = 1'b0; sv = 1'b0; otr = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check({ph, "_rst_tvalid"}, v_otv, 0);
    check({ph, "_rst_tlast"}, v_otl, 0);
    check({ph, "_rst_pulse"}, v_dp, 0);
    check({ph, "_rst_peak"}, v_pval, 0);
    check({ph, "_rst_dcnt"}, v_dcnt, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n, input bit skew, input bit bp, input int brk_out, input bit brk_rst);
    int ptr, cyc, last_fire;
    bit brk_done, rel, exp_tr, fire_s;
    ptr = 0; cyc = 0; last_fire = -1; brk_done = 0; rel = 0;
    got_q.delete(); got_det_at.delete(); got_det_val.delete(); viol = 0;
    while (ptr < n && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      clear = 1'b0;
      if (rel) begin
        reset = 1'b0;
        rel = 0;
      end
      mv = skew ? ($urandom_range(0, 3) != 0) : 1'b1;
      sv = skew ? ($urandom_range(0, 3) != 0) : 1'b1;
      otr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tlast = 1'($urandom); s_tlast = 1'($urandom);
      m_tdata = met[ptr]; s_tdata = smp[ptr];
      if (brk_out >= 0 && !brk_done && got_q.size() == brk_out) begin
        brk_done = 1;
        if (brk_rst) begin
          mv = 1'b1; sv = 1'b1; otr = 1'b1;
          #1;
          check("rst_mid_pre_tvalid", v_otv, 1);
          reset = 1'b1;
          #1;
          check("rst_mid_tvalid", v_otv, 0);
          check("rst_mid_tlast", v_otl, 0);
          check("rst_mid_dcnt", v_dcnt, 0);
          check("rst_mid_peak", v_pval, 0);
          rel = 1;
        end else begin
          clear = 1'b1;
        end
        mv = 1'b0; sv = 1'b0;
      end
      #1;
      if (v_dp) begin
        got_det_at.push_back(last_fire);
        got_det_val.push_back(v_pval);
      end
      exp_tr = mv && sv && (!inframe[ptr] || otr);
      if (v_mtr !== exp_tr || v_str !== exp_tr || v_otv !== (mv && sv && inframe[ptr])) viol++;
      if (v_otv && otr) got_q.push_back({v_otl, v_otd});
      fire_s = v_mtr;
      @(posedge clk);
      if (fire_s) begin
        last_fire = ptr;
        ptr++;
      end
    end
    @(negedge clk);
    mv = 1'b0; sv = 1'b0; clear = 1'b0; reset = 1'b0;
    check("stream_consumed", ptr, n);
  endtask

  task automatic compare(input string ph, input int exp_dc);
    int n;
    check({ph, "_out_count"}, got_q.size(), exp_idx.size());
    n = (got_q.size() < exp_idx.size()) ? got_q.size() : exp_idx.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_out%0d", ph, i), got_q[i], {exp_last[i], smp[exp_idx[i]]});
    check({ph, "_det_count"}, got_det_at.size(), exp_det_at.size());
    n = (got_det_at.size() < exp_det_at.size()) ? got_det_at.size() : exp_det_at.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_det%0d_at", ph, i), got_det_at[i], exp_det_at[i]);
      check($sformatf("%s_det%0d_val", ph, i), got_det_val[i], exp_det_val[i]);
    end
    check({ph, "_detect_count"}, v_dcnt, exp_dc);
    check({ph, "_handshake"}, viol, 0);
  endtask

  initial begin
    threshold = MW'(1000);
    mv = 0; sv = 0; otr = 0; m_tdata = '0; s_tdata = '0; m_tlast = 0; s_tlast = 0; sel = 0;

    setup_single(0);
    start_phase("single", 0);
    build_model(1600, SO, -1);
    run(1600, 0, 0, -1, 0);
    compare("single", exp_det_at.size());
    if (got_det_at.size() > 0) check("single_close_idx", got_det_at[0], 227);
    if (got_q.size() > 0) check("single_first", got_q[0], {1'b0, smp[357]});
    if (got_q.size() == FL) check("single_last", got_q[FL-1], {1'b1, smp[1508]});
    check("single_peak", v_pval, 3000);
    check("single_dcnt", v_dcnt, 1);

    setup_single(1);
    start_phase("tie", 0);
    build_model(1600, SO, -1);
    run(1600, 0, 0, -1, 0);
    compare("tie", exp_det_at.size());
    if (got_q.size() > 0) check("tie_first", got_q[0], {1'b0, smp[357]});

    setup_random();
    start_phase("rand_aligned", 0);
    build_model(3700, SO, -1);
    run(3700, 0, 0, -1, 0);
    compare("rand_aligned", exp_det_at.size());
    start_phase("rand_skew_bp", 0);
    run(3700, 1, 1, -1, 0);
    compare("rand_skew_bp", exp_det_at.size());

    setup_base();
    met[100] = MW'(3000);
    for (int i = 101; i <= 150; i++) met[i] = MW'(1500);
    start_phase("minoff", 1);
    build_model(1450, SO_B, -1);
    run(1450, 0, 0, -1, 0);
    compare("minoff", exp_det_at.size());
    if (got_q.size() > 0) check("minoff_first", got_q[0], {1'b0, smp[228]});

    setup_single(0);
    met[1300] = MW'(2500);
    for (int i = 1301; i <= 1350; i++) met[i] = MW'(1200);
    start_phase("clear", 0);
    build_model(2800, SO, -1);
    c_idx = exp_idx[500];
    build_model(2800, SO, c_idx);
    run(2800, 0, 0, 500, 0);
    compare("clear", exp_det_at.size());
    check("clear_dcnt_kept", v_dcnt, 2);

    start_phase("reset", 0);
    build_model(2800, SO, c_idx);
    run(2800, 0, 0, 500, 1);
    compare("reset", exp_det_at.size() - n_before);
    check("reset_dcnt_after", v_dcnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
